// File: rtl/special_alu_multi.sv
// Buffered operand reduction unit: channel A fills a DEPTH-entry operand store,
// channel B requests one of eight reductions and gets a registered result strobe.
module special_alu_multi #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 8,
  parameter bit DRAIN_ON_READ = 1'b1,
  localparam int RES_W = DATA_W + $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DATA_W-1:0] a_operand,
  input  logic              b_ready,
  input  logic [2:0]        b_operation,
  output logic              b_valid,
  output logic [RES_W-1:0]  b_result,
  output logic              b_empty,
  output logic [1:0]        dbg_state
);
  // Handshakes: an operand moves on a clock edge where a_valid && a_ready; an
  // operation is accepted on an edge where b_ready is high in IDLE; b_valid is a
  // one-cycle strobe with b_result/b_empty held until the next strobe.

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  localparam logic [2:0] OP_SUM   = 3'd0;
  localparam logic [2:0] OP_MIN   = 3'd1;
  localparam logic [2:0] OP_MAX   = 3'd2;
  localparam logic [2:0] OP_COUNT = 3'd3;
  localparam logic [2:0] OP_XOR   = 3'd4;
  localparam logic [2:0] OP_AND   = 3'd5;
  localparam logic [2:0] OP_OR    = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_inc;
  logic [IDX_W-1:0]   idx;
  logic [2:0]         op_q;
  logic [RES_W-1:0]   acc;
  logic [RES_W-1:0]   acc_next;
  logic [RES_W-1:0]   acc_init;
  logic [RES_W-1:0]   operand_ext;
  logic               push;
  logic               direct;
  logic               last;
  logic               is_tally;

  assign a_ready   = (state_q == IDLE) && (count < CNT_W'(DEPTH)) && !rst;
  assign b_valid   = (state_q == DONE);
  assign dbg_state = state_q;

  assign push      = a_valid && a_ready;
  assign count_inc = count + CNT_W'(push);
  assign is_tally  = (b_operation == OP_COUNT) || (b_operation == OP_CLEAR);
  // COUNT/CLEAR and empty buffers never need to walk the store
  assign direct    = is_tally || (count_inc == '0);
  assign last      = (CNT_W'(idx) == count - CNT_W'(1));

  assign operand_ext = RES_W'(mem[idx]);

  always_comb begin
    acc_init = '0;
    if (b_operation == OP_MIN || b_operation == OP_AND) begin
      acc_init = RES_W'({DATA_W{1'b1}});
    end
  end

  always_comb begin
    acc_next = acc;
    case (op_q)
      OP_SUM: acc_next = acc + operand_ext;
      OP_MIN: acc_next = (operand_ext < acc) ? operand_ext : acc;
      OP_MAX: acc_next = (operand_ext > acc) ? operand_ext : acc;
      OP_XOR: acc_next = acc ^ operand_ext;
      OP_AND: acc_next = acc & operand_ext;
      OP_OR:  acc_next = acc | operand_ext;
      default: acc_next = acc;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (b_ready) begin
          state_d = direct ? DONE : CALC;
        end
      end
      CALC: begin
        if (last) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[count[IDX_W-1:0]] <= a_operand;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count    <= '0;
      idx      <= '0;
      op_q     <= OP_SUM;
      acc      <= '0;
      b_result <= '0;
      b_empty  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          count <= count_inc;
          if (b_ready) begin
            op_q <= b_operation;
            idx  <= '0;
            acc  <= acc_init;
            if (direct) begin
              b_result <= is_tally ? RES_W'(count_inc) : '0;
              b_empty  <= (count_inc == '0);
            end
          end
        end
        CALC: begin
          acc <= acc_next;
          idx <= idx + IDX_W'(1);
          if (last) begin
            b_result <= acc_next;
            b_empty  <= 1'b0;
          end
        end
        DONE: begin
          // CLEAR always empties; other reductions except COUNT follow the drain policy
          if (op_q == OP_CLEAR || (DRAIN_ON_READ && op_q != OP_COUNT)) begin
            count <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/special_alu_multi.md
Name: special_alu_multi

Overview:
Parametrised successor of special_alu. Operand channel A buffers up to DEPTH operands of DATA_W bits. Operation channel B requests one of eight reductions over the buffered set and returns a registered result with a valid pulse. Width, depth and drain-on-read policy are generic, and MIN/MAX/bitwise reductions and an explicit CLEAR are added. Sits between the operand producer and the operation requester, the same place special_alu occupies.

Parameters:
DATA_W, 8, operand width in bits (>=1)
DEPTH, 8, operand buffer entries (power of 2, >=2)
DRAIN_ON_READ, 1, 1: buffer emptied when a SUM/MIN/MAX/XOR/AND/OR result is returned; 0: buffer retained
RES_W (localparam), DATA_W+$clog2(DEPTH), result width; defaults give 11

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
a_valid  in  1  operand offered
a_ready  out  1  operand can be accepted
a_operand  in  DATA_W  operand value, unsigned
b_ready  in  1  requester asks for an operation
b_operation  in  3  opcode, sampled on request acceptance
b_valid  out  1  one-cycle result strobe
b_result  out  RES_W  result, registered, held until next b_valid
b_empty  out  1  qualifies b_valid: operation ran on zero operands

Behaviour:
- Reset (rst=1 at clk edge): FSM=IDLE, count=0, b_valid=0, b_result=0, b_empty=0. a_ready is 0 while rst is high. Reset mid-operation aborts it: no b_valid is produced.
- Storage: register array plus write index = count. a_ready = (state==IDLE) && (count<DEPTH) && !rst. A push occurs on a_valid&&a_ready and stores at index count, then count+1.
- FSM states: IDLE, CALC, DONE.
- IDLE: if b_ready=1 at edge N, latch b_operation and go to CALC. COUNT, CLEAR, or count==0 (after the same-cycle push) go straight to DONE.
- A push in the same cycle N is included in the operation.
- CALC: one entry per cycle, index 0..count-1, into an accumulator. Lasts count cycles, then DONE.
- DONE: b_valid=1 for exactly one cycle with b_result and b_empty valid, then IDLE.
- Latency: b_valid at cycle N+count+1 for iterating ops; N+1 for COUNT, CLEAR and empty buffer.
- b_ready held high gives back-to-back operations: a new accept occurs in the IDLE cycle after DONE. b_ready deassert during CALC is ignored; the operation completes.
- Opcodes (results zero-extended to RES_W):
  - 0 SUM: sum of operands; cannot overflow RES_W.
  - 1 MIN.
  - 2 MAX.
  - 3 COUNT: count; never drains.
  - 4 XOR.
  - 5 AND.
  - 6 OR.
  - 7 CLEAR: returns count, then count=0 regardless of DRAIN_ON_READ.
- Empty buffer for ops 0,1,2,4,5,6: b_result=0, b_empty=1. COUNT/CLEAR on empty: result 0, b_empty=1.
- Drain: if DRAIN_ON_READ=1, count=0 on the DONE edge for ops 0,1,2,4,5,6.
- Full: count==DEPTH forces a_ready=0. The offered operand stays pending; it is not dropped and not overwritten.
- a_operand is ignored unless a push occurs. b_operation is ignored outside IDLE.

Test Plan:
- Reset: rst=1 for 3 cycles with a_valid=1, b_ready=1 -> a_ready=0, b_valid=0, b_result=0 throughout; a_ready=1 on the first cycle after release.
- Sum/drain (DRAIN_ON_READ=1): push 3, 250, 7; request SUM at N -> b_valid only at N+4, b_result=260 (0x104), b_empty=0. Then COUNT -> b_result=0 at accept+1, b_empty=1.
- Full: offer nine operands of 255 -> a_ready=0 after the 8th, 9th stays pending. SUM -> 2040 (0x7F8). After drain, a_ready=1 and the pending 255 is accepted.
- Retain (DRAIN_ON_READ=0): push 9, 2, 200.
  - MIN -> 2; MAX -> 200; OR -> 203; AND -> 0; COUNT -> 3.
  - CLEAR -> 3, then COUNT -> 0 with b_empty=1.
- Simultaneous: push 0x0F; in one cycle push 0x05 and request XOR -> result 0x0A, b_valid at accept+3. Holding b_ready high gives a second XOR (empty after drain) at the next IDLE with b_result=0, b_empty=1.
- Abort: push four operands, request SUM, assert rst in the 2nd CALC cycle -> b_valid never asserted. After reset, COUNT -> 0.
